// File: rtl/aes_to_tx.sv
// aes_to_tx: serialises a 128-bit AES block as 16 back-to-back 8N1 UART frames,
// byte 0 first, followed by a one-cycle done pulse in the first idle cycle.
module aes_to_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic         clk,
    input  logic         rst_tx,
    input  logic [127:0] data,
    input  logic         load_tx,
    output logic         ready_tx,
    output logic         sig_tx,
    output logic [7:0]   tx_byte,
    output logic         done_tx
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [3:0]         byte_cnt_q, byte_cnt_d;
    logic [127:0]       hold_q, hold_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               sig_q, sig_d;
    logic               done_q, done_d;
    logic               bit_end;
    logic [3:0]         byte_nxt;
    logic [2:0]         bit_nxt;

    assign bit_end  = (baud_q == BAUD_LAST);
    assign byte_nxt = byte_cnt_q + 4'd1;
    assign bit_nxt  = bit_idx_q + 3'd1;

    always_ff @(posedge clk or negedge rst_tx) begin
        if (!rst_tx) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_tx) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
            STOP:    if (bit_end) state_d = (byte_cnt_q == 4'd15) ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath; sig_tx is always a flop output.
    always_comb begin
        ready_tx   = (state_q == IDLE);
        baud_d     = ((state_q == IDLE) || bit_end) ? '0 : baud_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        byte_cnt_d = byte_cnt_q;
        hold_d     = hold_q;
        tx_byte_d  = tx_byte_q;
        sig_d      = sig_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                sig_d = 1'b1;
                if (load_tx) begin
                    hold_d     = data;
                    tx_byte_d  = data[7:0];
                    byte_cnt_d = 4'd0;
                    bit_idx_d  = 3'd0;
                    sig_d      = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_d = 3'd0;
                    sig_d     = tx_byte_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        sig_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_nxt;
                        sig_d     = tx_byte_q[bit_nxt];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_cnt_q == 4'd15) begin
                        done_d = 1'b1;
                        sig_d  = 1'b1;
                    end else begin
                        byte_cnt_d = byte_nxt;
                        tx_byte_d  = hold_q[{byte_nxt, 3'b000} +: 8];
                        sig_d      = 1'b0;
                    end
                end
            end
            default: begin
                sig_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_tx) begin
        if (!rst_tx) begin
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            byte_cnt_q <= 4'd0;
            hold_q     <= '0;
            tx_byte_q  <= 8'h00;
            sig_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_cnt_q <= byte_cnt_d;
            hold_q     <= hold_d;
            tx_byte_q  <= tx_byte_d;
            sig_q      <= sig_d;
            done_q     <= done_d;
        end
    end

    assign sig_tx  = sig_q;
    assign tx_byte = tx_byte_q;
    assign done_tx = done_q;

endmodule

// File: doc/aes_to_tx.md
AES_TO_TX -- requirements
Module: aes_to_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_tx  input  1  asynchronous active-low reset.
REQ-004 SHALL have port data  input  128  AES block to transmit; byte k = data[8k+7:8k].
REQ-005 SHALL have port load_tx  input  1  request to send data; sampled only when ready_tx=1.
REQ-006 SHALL have port ready_tx  output  1  high when idle and able to accept load_tx.
REQ-007 SHALL have port sig_tx  output  1  UART serial line; idle high.
REQ-008 SHALL have port tx_byte  output  8  byte currently being framed; for debug.
REQ-009 SHALL have port done_tx  output  1  one-cycle pulse when the 16th stop bit completes.

Function
REQ-010 SHALL capture all 128 bits of data into an internal holding register in the cycle load_tx=1 and ready_tx=1 (accept cycle); later changes on data SHALL NOT affect the transfer.
REQ-011 SHALL transmit bytes in order byte 0 first through byte 15 last, so that a receiver shifting bytes into the MSB end rebuilds the same 128-bit word.
REQ-012 SHALL frame each byte 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); no parity.
REQ-013 SHALL hold every bit on sig_tx for exactly CLKS_PER_BIT cycles; one frame = 10*CLKS_PER_BIT cycles.
REQ-014 SHALL drive the start bit of byte 0 on sig_tx starting the cycle after the accept cycle.
REQ-015 SHALL send the 16 frames back to back: start bit of byte k+1 begins the cycle after the stop bit of byte k ends; total transfer = 160*CLKS_PER_BIT cycles.
REQ-016 SHALL implement states IDLE, START, DATA, STOP: IDLE->START on accept; START->DATA after CLKS_PER_BIT; DATA->STOP after 8 bit periods; STOP->START if bytes sent <16, else STOP->IDLE.
REQ-017 SHALL use a 4-bit byte counter (0..15) and a 3-bit bit index (0..7); neither SHALL wrap inside a transfer.
REQ-018 SHALL use a baud counter wide enough for CLKS_PER_BIT-1, cleared at every bit boundary.
REQ-019 SHALL drive ready_tx=1 only in IDLE; load_tx while ready_tx=0 SHALL be ignored with no queuing.
REQ-020 SHALL assert done_tx for exactly one cycle, the first IDLE cycle after the final stop bit; ready_tx SHALL be 1 in that same cycle.
REQ-021 SHALL accept load_tx asserted in the done_tx cycle as a new transfer, with start bit the next cycle.
REQ-022 SHALL update tx_byte to the current byte at entry to START and hold it through STOP; in IDLE it SHALL hold the last byte sent.
REQ-023 SHALL keep sig_tx registered and glitch-free; sig_tx SHALL be 1 in IDLE.

Reset
REQ-024 SHALL, on rst_tx=0, immediately (asynchronously) force state IDLE, sig_tx=1, ready_tx=1, done_tx=0, tx_byte=8'h00, and clear holding register and all counters.
REQ-025 SHALL abort any in-progress transfer on reset with no done_tx pulse; after release, only a new load_tx starts a transfer.
REQ-026 SHALL accept load_tx no earlier than the first rising clk edge after rst_tx deasserts.

Verification
REQ-027 Basic: CLKS_PER_BIT=4, data=128'h0F0E0D0C0B0A09080706050403020100, pulse load_tx -> 16 frames carrying bytes 00,01,...,0F; done_tx pulses once 640 cycles after the accept cycle.
REQ-028 Bit timing: data=all 8'h55 -> sig_tx alternates 0,1,0,1,... each level held exactly 4 cycles; stop bit high 4 cycles; no gaps between frames.
REQ-029 Busy ignore: pulse load_tx with different data mid-transfer -> ready_tx stays 0, transmitted bytes unchanged, exactly one done_tx pulse.
REQ-030 Back-to-back: assert load_tx in the done_tx cycle with data=128'hFF..FF -> next start bit the following cycle; 16 frames of 8'hFF.
REQ-031 Reset mid-frame: assert rst_tx during byte 5 DATA state -> sig_tx=1 and ready_tx=1 without a clock edge; no done_tx; a fresh load_tx restarts from byte 0.
REQ-032 Loopback: connect sig_tx to the team UART receiver and its 128-bit assembler -> assembled word equals data after 16 bytes.
